// File: rtl/div_pkg.sv
// Shared types and constants for the non-restoring divider.
// Holds the FSM state encoding and the divide-by-zero quotient value.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int MAXW = 64;

    // All-ones quotient of the requested width, returned on divide by zero.
    function automatic logic [MAXW-1:0] dz_quotient(input int width);
        return {MAXW{1'b1}} >> (MAXW - width);
    endfunction

endpackage

// File: rtl/nr_div_ctrl.sv
// FSM and iteration counter for the non-restoring divider.
// Ports: Clock/Reset, Start, rneg (sign of R), divzero; per-state strobes out.
module nr_div_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Start,
    input  logic rneg,
    input  logic divzero,
    output logic load,
    output logic shift,
    output logic add,
    output logic fix,
    output logic fixadd,
    output logic busy,
    output logic done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] cnt;

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (Start) state_n = divzero ? DONE : ITER;
            ITER: if (cnt == LAST) state_n = FIX;
            FIX:  state_n = DONE;
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            if (state == ITER && cnt != LAST)
                cnt <= cnt + 1'b1;
            else
                cnt <= '0;
        end
    end

    assign load   = (state == IDLE) && Start;
    assign shift  = (state == ITER);
    // Negative R: restore by adding D instead of subtracting.
    assign add    = shift && rneg;
    assign fix    = (state == FIX);
    assign fixadd = fix && rneg;
    assign busy   = (state != IDLE);
    assign done   = (state == DONE);

endmodule

// File: rtl/nr_divider.sv
// Non-restoring sequential divider, one quotient bit per clock, signed/unsigned.
// Ports: Start/Signed/Dividend/Divisor in; Quotient/Remainder/Busy/Done/flags out.
module nr_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Signed,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero,
    output logic             Overflow
);

    localparam logic [WIDTH-1:0] DZ_Q = WIDTH'(dz_quotient(WIDTH));
    localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH:0]   r;
    logic [WIDTH:0]   shin;
    logic [WIDTH:0]   dext;
    logic [WIDTH:0]   rsum;
    logic [WIDTH:0]   rfix;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] qfin;
    logic [WIDTH-1:0] rfin;
    logic             negq;
    logic             negr;
    logic             ovf_p;
    logic             divzero;
    logic             load;
    logic             shift;
    logic             add;
    logic             fix;
    logic             fixadd;

    nr_div_ctrl #(.WIDTH(WIDTH)) u_ctrl (
        .Clock   (Clock),
        .Reset   (Reset),
        .Start   (Start),
        .rneg    (r[WIDTH]),
        .divzero (divzero),
        .load    (load),
        .shift   (shift),
        .add     (add),
        .fix     (fix),
        .fixadd  (fixadd),
        .busy    (Busy),
        .done    (Done)
    );

    assign divzero = (Divisor == '0);
    assign dvd_mag = (Signed && Dividend[WIDTH-1]) ? -Dividend : Dividend;
    assign dvs_mag = (Signed && Divisor[WIDTH-1]) ? -Divisor : Divisor;

    // q doubles as dividend shifter: MSB feeds R, new quotient bit enters LSB.
    assign shin = {r[WIDTH-1:0], q[WIDTH-1]};
    assign dext = {1'b0, d};
    assign rsum = add ? shin + dext : shin - dext;
    assign rfix = fixadd ? r + dext : r;
    assign qfin = negq ? -q : q;
    assign rfin = negr ? -rfix[WIDTH-1:0] : rfix[WIDTH-1:0];

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r         <= '0;
            d         <= '0;
            q         <= '0;
            negq      <= 1'b0;
            negr      <= 1'b0;
            ovf_p     <= 1'b0;
            Quotient  <= '0;
            Remainder <= '0;
            DivZero   <= 1'b0;
            Overflow  <= 1'b0;
        end else begin
            if (load) begin
                r        <= '0;
                d        <= dvs_mag;
                q        <= dvd_mag;
                negq     <= Signed && (Dividend[WIDTH-1] ^ Divisor[WIDTH-1]);
                negr     <= Signed && Dividend[WIDTH-1];
                ovf_p    <= Signed && (Dividend == MINV) && (Divisor == '1);
                DivZero  <= divzero;
                Overflow <= 1'b0;
                if (divzero) begin
                    Quotient  <= DZ_Q;
                    Remainder <= Dividend;
                end
            end
            if (shift) begin
                r <= rsum;
                q <= {q[WIDTH-2:0], ~rsum[WIDTH]};
            end
            if (fix) begin
                r         <= rfix;
                Quotient  <= qfin;
                Remainder <= rfin;
                Overflow  <= ovf_p;
            end
        end
    end

endmodule

// File: tb/tb_nr_divider.sv
// Self-checking bench for nr_divider: vector table with scoreboard queue,
// plus hand sequences for ignored Start, mid-divide reset and WIDTH=16.
module tb_nr_divider;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic        Signed = 1'b0;
    logic [7:0]  Dividend = '0;
    logic [7:0]  Divisor = '0;
    logic [7:0]  Quotient;
    logic [7:0]  Remainder;
    logic        Busy;
    logic        Done;
    logic        DivZero;
    logic        Overflow;

    logic        Start16 = 1'b0;
    logic        Signed16 = 1'b0;
    logic [15:0] Dividend16 = '0;
    logic [15:0] Divisor16 = '0;
    logic [15:0] Quotient16;
    logic [15:0] Remainder16;
    logic        Busy16;
    logic        Done16;
    logic        DivZero16;
    logic        Overflow16;

    always #5 Clock = ~Clock;

    nr_divider #(.WIDTH(8)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Start     (Start),
        .Signed    (Signed),
        .Dividend  (Dividend),
        .Divisor   (Divisor),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .Busy      (Busy),
        .Done      (Done),
        .DivZero   (DivZero),
        .Overflow  (Overflow)
    );

    nr_divider #(.WIDTH(16)) dut16 (
        .Clock     (Clock),
        .Reset     (Reset),
        .Start     (Start16),
        .Signed    (Signed16),
        .Dividend  (Dividend16),
        .Divisor   (Divisor16),
        .Quotient  (Quotient16),
        .Remainder (Remainder16),
        .Busy      (Busy16),
        .Done      (Done16),
        .DivZero   (DivZero16),
        .Overflow  (Overflow16)
    );

    typedef struct {
        logic       sgn;
        logic [7:0] dvd;
        logic [7:0] dvs;
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        logic       ov;
        int         lat;
    } vec_t;

    vec_t vecs[12];
    vec_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called just after a negedge; returns just after a negedge.
    task automatic run(input vec_t v, input int p1, input int p2);
        int   cyc;
        bit   busy_ok;
        vec_t e;
        Signed   = v.sgn;
        Dividend = v.dvd;
        Divisor  = v.dvs;
        Start    = 1'b1;
        exp_q.push_back(v);
        @(negedge Clock);
        cyc      = 1;
        busy_ok  = 1'b1;
        Start    = 1'b0;
        Dividend = 8'hA5;
        Divisor  = 8'h0C;
        while (!Done && cyc < 40) begin
            if (!Busy) busy_ok = 1'b0;
            Start = (cyc == p1) || (cyc == p2);
            @(negedge Clock);
            cyc++;
        end
        e = exp_q.pop_front();
        chk("done_seen", {31'd0, Done}, 32'd1);
        chk("latency", cyc, e.lat);
        chk("busy_window", {31'd0, busy_ok}, 32'd1);
        chk("busy_at_done", {31'd0, Busy}, 32'd1);
        chk("quotient", {24'd0, Quotient}, {24'd0, e.q});
        chk("remainder", {24'd0, Remainder}, {24'd0, e.r});
        chk("divzero", {31'd0, DivZero}, {31'd0, e.dz});
        chk("overflow", {31'd0, Overflow}, {31'd0, e.ov});
        Start = (cyc == p1) || (cyc == p2);
        @(negedge Clock);
        Start = 1'b0;
        chk("idle_busy", {31'd0, Busy}, 32'd0);
        chk("idle_done", {31'd0, Done}, 32'd0);
        chk("held_quotient", {24'd0, Quotient}, {24'd0, e.q});
    endtask

    task automatic run16(input logic sgn, input logic [15:0] dvd,
                         input logic [15:0] dvs, input logic [15:0] eq,
                         input logic [15:0] er, input int lat);
        int cyc;
        Signed16   = sgn;
        Dividend16 = dvd;
        Divisor16  = dvs;
        Start16    = 1'b1;
        @(negedge Clock);
        cyc     = 1;
        Start16 = 1'b0;
        while (!Done16 && cyc < 60) begin
            @(negedge Clock);
            cyc++;
        end
        chk("w16_done_seen", {31'd0, Done16}, 32'd1);
        chk("w16_latency", cyc, lat);
        chk("w16_quotient", {16'd0, Quotient16}, {16'd0, eq});
        chk("w16_remainder", {16'd0, Remainder16}, {16'd0, er});
        chk("w16_overflow", {31'd0, Overflow16}, 32'd0);
        @(negedge Clock);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 8'd200, 8'd7,   8'd28,  8'd4,   1'b0, 1'b0, 10};
        vecs[1]  = '{1'b1, 8'hF9,  8'd2,   8'hFD,  8'hFF,  1'b0, 1'b0, 10};
        vecs[2]  = '{1'b1, 8'd7,   8'hFE,  8'hFD,  8'h01,  1'b0, 1'b0, 10};
        vecs[3]  = '{1'b0, 8'd55,  8'd0,   8'hFF,  8'd55,  1'b1, 1'b0, 1};
        vecs[4]  = '{1'b0, 8'd9,   8'd3,   8'd3,   8'd0,   1'b0, 1'b0, 10};
        vecs[5]  = '{1'b1, 8'h80,  8'hFF,  8'h80,  8'd0,   1'b0, 1'b1, 10};
        vecs[6]  = '{1'b0, 8'h80,  8'hFF,  8'd0,   8'd128, 1'b0, 1'b0, 10};
        vecs[7]  = '{1'b1, 8'd55,  8'd0,   8'hFF,  8'd55,  1'b1, 1'b0, 1};
        vecs[8]  = '{1'b0, 8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 1'b0, 10};
        vecs[9]  = '{1'b1, 8'h9C,  8'hF9,  8'd14,  8'hFE,  1'b0, 1'b0, 10};
        vecs[10] = '{1'b0, 8'd3,   8'd200, 8'd0,   8'd3,   1'b0, 1'b0, 10};
        vecs[11] = '{1'b1, 8'd100, 8'hF9,  8'hF2,  8'd2,   1'b0, 1'b0, 10};

        repeat (3) @(negedge Clock);
        chk("rst_quotient", {24'd0, Quotient}, 32'd0);
        chk("rst_remainder", {24'd0, Remainder}, 32'd0);
        chk("rst_busy", {31'd0, Busy}, 32'd0);
        chk("rst_done", {31'd0, Done}, 32'd0);
        chk("rst_divzero", {31'd0, DivZero}, 32'd0);
        chk("rst_overflow", {31'd0, Overflow}, 32'd0);
        Reset = 1'b0;
        @(negedge Clock);

        for (int i = 0; i < 12; i++) run(vecs[i], -1, -1);

        // Start pulses mid-divide and in the Done cycle must be ignored.
        run(vecs[0], 3, 10);
        chk("ign_still_idle", {31'd0, Busy}, 32'd0);

        // Reset in cycle 5 of a divide.
        Signed   = 1'b0;
        Dividend = 8'd200;
        Divisor  = 8'd7;
        Start    = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        repeat (4) @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        chk("mid_rst_quotient", {24'd0, Quotient}, 32'd0);
        chk("mid_rst_remainder", {24'd0, Remainder}, 32'd0);
        chk("mid_rst_busy", {31'd0, Busy}, 32'd0);
        chk("mid_rst_done", {31'd0, Done}, 32'd0);
        chk("mid_rst_divzero", {31'd0, DivZero}, 32'd0);
        chk("mid_rst_overflow", {31'd0, Overflow}, 32'd0);
        run('{1'b0, 8'd5, 8'd9, 8'd0, 8'd5, 1'b0, 1'b0, 10}, -1, -1);

        run16(1'b0, 16'd60000, 16'd255, 16'd235, 16'd75, 18);
        run16(1'b1, 16'hFC18, 16'd7, 16'hFF72, 16'hFFFA, 18);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/nr_divider.md
# nr_divider

Parametrised non-restoring sequential divider with integrated datapath, unsigned/signed mode, divide-by-zero and signed-overflow flags. It is the generalised successor to the calculator's 8-bit divide control. The block sits beside the add/sub/multiply units and is driven by the calculator top-level through a Start/Busy/Done handshake. It produces one quotient bit per clock.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- Clock  input  1  rising-edge clock
- Reset  input  1  synchronous, active-high
- Start  input  1  begin a divide; sampled only when Busy=0
- Signed  input  1  1 = two's-complement operands; sampled with Start
- Dividend  input  WIDTH  sampled with Start
- Divisor  input  WIDTH  sampled with Start
- Quotient  output  WIDTH  result; held until next accepted Start
- Remainder  output  WIDTH  result; held until next accepted Start
- Busy  output  1  high from the cycle after an accepted Start through the Done cycle, inclusive
- Done  output  1  one-cycle pulse; results are valid in that cycle
- DivZero  output  1  Divisor was 0; held with results
- Overflow  output  1  signed (−2^(WIDTH−1)) / (−1); held with results

## Operation
- States: IDLE, ITER, FIX, DONE.
- IDLE, Start=1: latch Signed and the operand signs. Load magnitudes |Dividend| and |Divisor| (unsigned mode: raw values). Clear the (WIDTH+1)-bit partial remainder R and the iteration counter.
  - Divisor==0: go to DONE.
  - Otherwise: go to ITER.
- ITER, one cycle per quotient bit, WIDTH cycles, MSB first:
  - If R≥0: R ← (R<<1 | next dividend bit) − D.
  - Else: R ← (R<<1 | next dividend bit) + D.
  - Quotient bit ← ~R[WIDTH] (sign of the new R).
  - The counter wraps to 0 after WIDTH−1, then go to FIX.
- FIX:
  - If R<0: R ← R + D.
  - Signed mode: negate the quotient if the operand signs differ, and negate the remainder if the dividend was negative. This gives truncation toward zero, with the remainder taking the dividend's sign.
  - Then go to DONE.
- DONE: Done=1 and Busy=1; Quotient/Remainder/flags update on entry. Go to IDLE.
- Divide by zero: Quotient = all ones, Remainder = Dividend (raw), DivZero=1, Overflow=0.
- Signed overflow: Quotient = 10…0 (natural wrap), Remainder = 0, Overflow=1, normal latency.
- Unsigned mode never sets Overflow.
- DivZero and Overflow clear on the next accepted Start.
- Start while Busy=1 is ignored, and operands are not resampled.
- Start asserted in the DONE cycle is ignored. Start is accepted again from IDLE.

## Timing
- Cycle 0 is the cycle in which Start=1 is accepted.
- Normal divide: Busy=1 in cycles 1..WIDTH+2. Done=1 and results valid in cycle WIDTH+2 (WIDTH=8 → cycle 10).
- Divide by zero: Busy=1 and Done=1 in cycle 1 only.
- Back-to-back: the earliest next accepted Start is cycle WIDTH+3.
- Reset (any state, including mid-iteration): next state IDLE. Quotient=0, Remainder=0, Busy=0, Done=0, DivZero=0, Overflow=0. The internal R, D and counter are cleared.
- Reset has priority over Start in the same cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package div_pkg holds:
  - the state enum (IDLE, ITER, FIX, DONE);
  - the quotient value returned on divide by zero (all-ones function of WIDTH).
- Sub-module nr_div_ctrl holds the FSM and iteration counter. Its inputs are Start, Reset, the sign of R and the divide-by-zero flag. It emits per-state load/shift/addsub/fix strobes.
- nr_divider instantiates nr_div_ctrl and holds the R/D/Q registers, the add/sub unit and the sign-correction logic.

## Test plan
- Unsigned, WIDTH=8: 200/7 → Q=28, R=4. Done exactly in cycle 10, Busy cycles 1–10.
- Signed: −7/2 → Q=0xFD (−3), R=0xFF (−1). Also 7/−2 → Q=0xFD, R=0x01.
- 55/0 (either mode) → Q=0xFF, R=55, DivZero=1, Done in cycle 1. A following 9/3 → Q=3, R=0, DivZero=0.
- Signed −128/−1 → Q=0x80, R=0, Overflow=1. The same operands unsigned (128/255) → Q=0, R=128, Overflow=0.
- Start pulsed in cycles 3 and 10 of a 200/7 divide → ignored; results unchanged.
- Reset asserted in cycle 5 → all outputs 0 next cycle. A new 5/9 started afterwards → Q=0, R=5.
- WIDTH=16 build: 60000/255 unsigned → Q=235, R=75, Done in cycle 18.
